// File: rtl/fp16_pkg.sv
// fp16_pkg: binary16 constants, field positions, flag struct and the combinational multiply used by fp16_multiplier.
package fp16_pkg;
  localparam int FP16_W = 16;
  localparam int FP16_MUL_LATENCY = 6;
  localparam logic [15:0] FP16_QNAN = 16'h7e00;
  localparam logic [15:0] FP16_INF = 16'h7c00;
  localparam int EXP_MSB = 14;
  localparam int EXP_LSB = 10;
  localparam int FRAC_MSB = 9;
  localparam int FRAC_LSB = 0;
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic subnormal;
  } fp16_flags_t;
  function automatic fp16_flags_t fp16_flags(input logic [15:0] x);
    logic eo, ez, fz;
    eo = &x[EXP_MSB:EXP_LSB];
    ez = ~|x[EXP_MSB:EXP_LSB];
    fz = ~|x[FRAC_MSB:FRAC_LSB];
    return '{nan: eo & ~fz, inf: eo & fz, zero: ez & fz, subnormal: ez & ~fz};
  endfunction
  // Round-to-nearest-even product with gradual underflow; any NaN or inf*0 yields the canonical quiet NaN.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic s, an, bn, ai, bi, az, bz, st, rnd;
    logic [4:0] ea, eb, l;
    logic [10:0] ma, mb;
    logic [21:0] p, pn;
    int e, sh;
    s = a[15] ^ b[15];
    ea = a[EXP_MSB:EXP_LSB];
    eb = b[EXP_MSB:EXP_LSB];
    an = &ea & |a[FRAC_MSB:FRAC_LSB];
    bn = &eb & |b[FRAC_MSB:FRAC_LSB];
    ai = &ea & ~|a[FRAC_MSB:FRAC_LSB];
    bi = &eb & ~|b[FRAC_MSB:FRAC_LSB];
    az = ~|a[14:0];
    bz = ~|b[14:0];
    if (an | bn | (ai & bz) | (bi & az)) return FP16_QNAN;
    if (ai | bi) return {s, FP16_INF[14:0]};
    if (az | bz) return {s, 15'h0};
    ma = {|ea, a[FRAC_MSB:FRAC_LSB]};
    mb = {|eb, b[FRAC_MSB:FRAC_LSB]};
    p = ma * mb;
    l = '0;
    for (int i = 0; i < 22; i++) if (p[i]) l = 5'(i);
    pn = p << (5'd21 - l);
    e = int'({ea[4:1], ea[0] | ~|ea}) + int'({eb[4:1], eb[0] | ~|eb}) - 35 + int'(l);
    st = 1'b0;
    if (e < 1) begin
      sh = (1 - e > 22) ? 22 : 1 - e;
      st = |(pn & ((22'h1 << sh) - 22'h1));
      pn = pn >> sh;
      e = 0;
    end
    rnd = pn[10] & (st | |pn[9:0] | pn[11]);
    if (e >= 31) return {s, FP16_INF[14:0]};
    return {s, 5'(e), pn[20:11]} + {15'd0, rnd};
  endfunction
endpackage

// File: rtl/fp16_mul_fifo.sv
// fp16_mul_fifo: synchronous FIFO with explicit pointer wrap so DEPTH need not be a power of two.
module fp16_mul_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push_i ? (wr_q == PW'(DEPTH-1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d = pop_i ? (rd_q == PW'(DEPTH-1) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= din_i;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fp16_multiplier.sv
// fp16_multiplier: binary16 multiply with a fixed FP16_MUL_LATENCY-cycle, unreset, non-stalling pipeline.
module fp16_multiplier
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic [FP16_W-1:0] a_i,
  input  logic [FP16_W-1:0] b_i,
  output logic [FP16_W-1:0] out_o
);
  logic [FP16_W-1:0] pipe_q [FP16_MUL_LATENCY];
  always_ff @(posedge clk) begin
    pipe_q[0] <= fp16_mul(a_i, b_i);
    for (int i = 1; i < FP16_MUL_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign out_o = pipe_q[FP16_MUL_LATENCY-1];
endmodule

// File: rtl/fp16_mul_stream.sv
// fp16_mul_stream: credit-admitted valid/ready shell around fp16_multiplier with an in-order result FIFO.
// Define FP16_MUL_FLAGS_EN to add the m_flags port (flags stored alongside each result).
module fp16_mul_stream
  import fp16_pkg::*;
#(
  parameter int LATENCY = FP16_MUL_LATENCY,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FP16_W-1:0] s_a,
  input  logic [FP16_W-1:0] s_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FP16_W-1:0] m_data,
`ifdef FP16_MUL_FLAGS_EN
  output logic [3:0]        m_flags,
`endif
  output logic              busy
);
  localparam int CW = $clog2(DEPTH+1);
`ifdef FP16_MUL_FLAGS_EN
  localparam int FW = FP16_W + 4;
`else
  localparam int FW = FP16_W;
`endif
  logic issue, pop, s_ready_q;
  logic [LATENCY-1:0] vpipe_q, vpipe_d;
  logic [CW-1:0] credits_q, credits_d, count;
  logic [FP16_W-1:0] prod;
  logic [FW-1:0] din, dout;
  assign issue = s_valid & s_ready_q;
  assign pop = m_valid & m_ready;
  always_comb begin
    vpipe_d = {vpipe_q[LATENCY-2:0], issue};
    credits_d = (issue & ~pop) ? credits_q - CW'(1) : (pop & ~issue) ? credits_q + CW'(1) : credits_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= CW'(DEPTH);
      vpipe_q <= '0;
      s_ready_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      vpipe_q <= vpipe_d;
      s_ready_q <= credits_d != '0;
    end
  end
  fp16_multiplier u_mul (
    .clk   (clk),
    .a_i   (s_a),
    .b_i   (s_b),
    .out_o (prod)
  );
`ifdef FP16_MUL_FLAGS_EN
  assign din = {fp16_flags(prod), prod};
  assign m_flags = dout[FW-1:FP16_W];
`else
  assign din = prod;
`endif
  // Credits cap occupancy at DEPTH, so a push never meets a full FIFO.
  fp16_mul_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (vpipe_q[LATENCY-1]),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (dout),
    .count_o (count)
  );
  assign m_valid = count != '0;
  assign m_data = dout[FP16_W-1:0];
  assign s_ready = s_ready_q;
  assign busy = |vpipe_q | m_valid;
endmodule

// File: tb/tb_fp16_mul_stream.sv
// tb_fp16_mul_stream: directed vectors with hand-computed products, checked in order by a pop monitor.
module tb_fp16_mul_stream;
  logic clk = 1'b0, rst_n, s_valid, s_ready, m_valid, m_ready, busy;
  logic [15:0] s_a, s_b, m_data;
  logic [3:0] m_flags_w;
  logic [19:0] expq[$];
  int total = 0, bad = 0, cyc = 0, pops = 0, first_pop = 0, last_pop = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  fp16_mul_stream dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
`ifdef FP16_MUL_FLAGS_EN
    .m_flags (m_flags_w),
`endif
    .busy    (busy)
  );
`ifndef FP16_MUL_FLAGS_EN
  assign m_flags_w = 4'h0;
`endif
  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (pops == 0) first_pop = cyc;
      pops++;
      last_pop = cyc;
      if (expq.size() == 0) chk("extra_result", 20'h1, 20'h0);
      else begin
        logic [19:0] e;
        e = expq.pop_front();
        chk("m_data", {4'h0, m_data}, {4'h0, e[15:0]});
`ifdef FP16_MUL_FLAGS_EN
        chk("m_flags", {16'h0, m_flags_w}, {16'h0, e[19:16]});
`endif
      end
    end
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p, input logic [3:0] f);
    int n;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    n = 0;
    while (!s_ready && n < 50) begin
      step;
      n++;
    end
    if (!s_ready) chk("send_timeout", 20'h0, 20'h1);
    else expq.push_back({f, p});
    step;
    s_valid = 1'b0;
  endtask
  task automatic drain;
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      step;
      n++;
    end
    chk("drain_left", 20'(expq.size()), 20'h0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n;
    rst_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_a = '0;
    s_b = '0;
    repeat (3) step;
    chk("rst_s_ready", {19'h0, s_ready}, 20'h0);
    chk("rst_m_valid", {19'h0, m_valid}, 20'h0);
    chk("rst_m_data", {4'h0, m_data}, 20'h0);
    chk("rst_busy", {19'h0, busy}, 20'h0);
    chk("rst_m_flags", {16'h0, m_flags_w}, 20'h0);
    rst_n = 1'b1;
    step;
    chk("ready_after_rst", {19'h0, s_ready}, 20'h1);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_a = 16'h3C00;
    s_b = 16'h4000;
    expq.push_back({4'h0, 16'h4000});
    step;
    s_valid = 1'b0;
    n = 1;
    while (!m_valid && n < 20) begin
      step;
      n++;
    end
    chk("latency", 20'(n), 20'd7);
    step;
    step;
    chk("single_busy", {19'h0, busy}, 20'h0);
    pops = 0;
    for (int i = 0; i < 32; i++) begin
      chk("stream_ready", {19'h0, s_ready}, 20'h1);
      if (i % 2 == 0) send(16'h3800, 16'h3800, 16'h3400, 4'h0);
      else send(16'hC000, 16'h3C00, 16'hC000, 4'h0);
    end
    drain;
    chk("stream_pops", 20'(pops), 20'd32);
    chk("stream_rate", 20'(last_pop - first_pop), 20'd31);
    m_ready = 1'b0;
    pops = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_a = 16'h3C00;
      s_b = 16'h4000 + 16'(n * 16'h0400);
      if (s_ready) begin
        expq.push_back({4'h0, s_b});
        n++;
      end
      step;
    end
    s_valid = 1'b0;
    chk("bp_accepted", 20'(n), 20'd8);
    chk("bp_ready_low", {19'h0, s_ready}, 20'h0);
    repeat (8) step;
    chk("bp_hold_valid", {19'h0, m_valid}, 20'h1);
    chk("bp_hold_data", {4'h0, m_data}, 20'h4000);
    m_ready = 1'b1;
    chk("bp_ready_at_pop", {19'h0, s_ready}, 20'h0);
    step;
    chk("bp_ready_after_pop", {19'h0, s_ready}, 20'h1);
    drain;
    chk("bp_pops", 20'(pops), 20'd8);
    send(16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
    send(16'h7C00, 16'h4000, 16'h7C00, 4'b0100);
    send(16'h7BFF, 16'h4000, 16'h7C00, 4'b0100);
    send(16'h0000, 16'hC000, 16'h8000, 4'b0010);
    send(16'h0000, 16'h3C00, 16'h0000, 4'b0010);
    drain;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h3800, 16'h3800, 16'h3400, 4'h0);
    step;
    chk("mid_valid", {19'h0, m_valid}, 20'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", {19'h0, m_valid}, 20'h0);
    chk("mid_rst_s_ready", {19'h0, s_ready}, 20'h0);
    chk("mid_rst_busy", {19'h0, busy}, 20'h0);
    expq.delete();
    step;
    step;
    rst_n = 1'b1;
    step;
    m_ready = 1'b1;
    repeat (15) step;
    chk("post_rst_busy", {19'h0, busy}, 20'h0);
    send(16'h3800, 16'h3800, 16'h3400, 4'h0);
    drain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
